// File: rtl/data_memory_access_unit.sv
// data_memory_access_unit
//   MEM-stage bridge from the EX/MEM register to a word-addressed data memory.
//   Each load/store runs as one req/ack transaction with a bounded wait.
//   data_ready_mem low stalls the whole pipeline until the access completes.
//   Optional feature macro: MEM_STORE_BUFFER_EN (1-entry posted store buffer).
//
//   Handshake: mem_req rises on the edge leaving IDLE and stays high, with
//   mem_we/mem_addr/mem_wdata frozen, until the edge on which mem_ack is
//   sampled high (or the wait budget runs out). mem_ack is a one-cycle pulse
//   and is ignored whenever mem_req is not high.
module data_memory_access_unit #(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              memread_mem,
  input  logic              memwrite_mem,
  input  logic [31:0]       alu_result_mem,
  input  logic [31:0]       write_data_memory_mem,
  output logic [31:0]       data_from_memory_mem,
  output logic              data_ready_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              mem_err,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last value of the wait counter before a missing ack is declared a timeout.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     finish_state;
  logic [7:0] wait_cnt;
  logic       is_load;
  logic       access;
  logic       load_req;
  logic       in_range;

  assign access    = memread_mem | memwrite_mem;
  // Read and write together behave as a store.
  assign load_req  = memread_mem & ~memwrite_mem;
  // Any address bit above the word-address field makes the access illegal.
  assign in_range  = ((alu_result_mem >> (ADDR_W + 2)) == 32'd0);
  assign state_dbg = state;

`ifdef MEM_STORE_BUFFER_EN
  // High while the transaction in REQ is a posted store the pipeline no
  // longer waits for; such a drain returns straight to IDLE with no ready pulse.
  logic draining;
  assign finish_state = draining ? IDLE : DONE;
`else
  assign finish_state = DONE;
`endif

  // Stall decode: ready whenever no access is waiting on this unit.
  always_comb begin
    data_ready_mem = 1'b0;
    case (state)
      IDLE: begin
`ifdef MEM_STORE_BUFFER_EN
        // An in-range store is posted without stalling (buffer is empty in IDLE).
        data_ready_mem = ~access | (memwrite_mem & in_range);
`else
        data_ready_mem = ~access;
`endif
      end
      REQ: begin
`ifdef MEM_STORE_BUFFER_EN
        data_ready_mem = draining & ~access;
`else
        data_ready_mem = 1'b0;
`endif
      end
      DONE:    data_ready_mem = 1'b1;
      default: data_ready_mem = 1'b0;
    endcase
    if (!rstn) data_ready_mem = 1'b1;
  end

  // Access FSM: latches the request in IDLE, waits for ack/timeout in REQ,
  // and gives the pipeline its single advance cycle in DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                <= IDLE;
      mem_req              <= 1'b0;
      mem_we               <= 1'b0;
      mem_addr             <= '0;
      mem_wdata            <= '0;
      data_from_memory_mem <= '0;
      mem_err              <= 1'b0;
      wait_cnt             <= '0;
      is_load              <= 1'b0;
`ifdef MEM_STORE_BUFFER_EN
      draining             <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            if (in_range) begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= memwrite_mem;
              mem_addr  <= alu_result_mem[ADDR_W+1:2];
              mem_wdata <= write_data_memory_mem;
              is_load   <= load_req;
              wait_cnt  <= '0;
`ifdef MEM_STORE_BUFFER_EN
              draining  <= memwrite_mem;
`endif
            end else begin
              // Illegal address: no bus cycle, flag it and return zero for loads.
              state   <= DONE;
              mem_err <= 1'b1;
              if (load_req) data_from_memory_mem <= '0;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            state   <= finish_state;
            mem_req <= 1'b0;
            if (is_load) data_from_memory_mem <= mem_rdata;
`ifdef MEM_STORE_BUFFER_EN
            draining <= 1'b0;
`endif
          end else if (wait_cnt == TMO_LAST) begin
            // Forced completion so a dead memory cannot hang the pipeline.
            state   <= finish_state;
            mem_req <= 1'b0;
            mem_err <= 1'b1;
            if (is_load) data_from_memory_mem <= '0;
`ifdef MEM_STORE_BUFFER_EN
            draining <= 1'b0;
`endif
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_access_unit.sv
// tb_data_memory_access_unit
//   Directed cases followed by randomized accesses against a transaction-level
//   model: each access is reduced to (stall length, bus cycles, result, error).
module tb_data_memory_access_unit;

  localparam int ADDR_W = 14;
  localparam int TMO    = 4;

  logic              clk;
  logic              rstn;
  logic              memread_mem;
  logic              memwrite_mem;
  logic [31:0]       alu_result_mem;
  logic [31:0]       write_data_memory_mem;
  logic [31:0]       data_from_memory_mem;
  logic              data_ready_mem;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              mem_err;
  logic [1:0]        state_dbg;

  int checks   = 0;
  int failures = 0;

  // Scoreboard of expected load-result register values, one per access.
  logic [31:0] exp_q[$];
  logic [31:0] model_data;
  logic        model_err;

  data_memory_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .memread_mem           (memread_mem),
    .memwrite_mem          (memwrite_mem),
    .alu_result_mem        (alu_result_mem),
    .write_data_memory_mem (write_data_memory_mem),
    .data_from_memory_mem  (data_from_memory_mem),
    .data_ready_mem        (data_ready_mem),
    .mem_req               (mem_req),
    .mem_we                (mem_we),
    .mem_addr              (mem_addr),
    .mem_wdata             (mem_wdata),
    .mem_rdata             (mem_rdata),
    .mem_ack               (mem_ack),
    .mem_err               (mem_err),
    .state_dbg             (state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pipeline cycle with no memory instruction in MEM.
  task automatic idle_cycle();
    memread_mem    = 1'b0;
    memwrite_mem   = 1'b0;
    alu_result_mem = $urandom;
    mem_ack        = 1'($urandom_range(0, 1));
    mem_rdata      = $urandom;
    #1;
    check("idle_ready", {31'd0, data_ready_mem}, 32'd1);
    check("idle_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
  endtask

  // One memory instruction presented to the unit, held until the pipeline
  // would advance. ack_delay = REQ cycles before the ack; >= TMO means no ack.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ack_delay);
    logic        load;
    logic        legal;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_low;
    int          exp_req;
    int          low;
    int          reqc;

    // Reference model: what the access must look like from outside.
    load  = rd && !wr;
    legal = (addr < (32'd1 << (ADDR_W + 2)));
    rdata = $urandom;
    if (!legal) begin
      exp_req  = 0;
      exp_low  = 1;
      exp_err  = 1'b1;
      exp_data = load ? 32'd0 : model_data;
    end else if (ack_delay < TMO) begin
      exp_req  = ack_delay + 1;
      exp_low  = 1 + exp_req;
      exp_err  = model_err;
      exp_data = load ? rdata : model_data;
    end else begin
      exp_req  = TMO;
      exp_low  = 1 + TMO;
      exp_err  = 1'b1;
      exp_data = load ? 32'd0 : model_data;
    end
    model_data = exp_data;
    model_err  = exp_err;
    exp_q.push_back(exp_data);

    memread_mem           = rd;
    memwrite_mem          = wr;
    alu_result_mem        = addr;
    write_data_memory_mem = wdata;
    mem_ack               = 1'($urandom_range(0, 1));
    mem_rdata             = $urandom;
    #1;
    check("ready_low_first", {31'd0, data_ready_mem}, 32'd0);

    low  = 0;
    reqc = 0;
    while (data_ready_mem !== 1'b1 && low < 40) begin
      if (low > 0) begin
        // The unit must ignore the inputs once it has left IDLE.
        memread_mem           = 1'($urandom_range(0, 1));
        memwrite_mem          = 1'($urandom_range(0, 1));
        alu_result_mem        = $urandom;
        write_data_memory_mem = $urandom;
      end
      low++;
      if (mem_req === 1'b1) begin
        check("req_addr", {18'd0, mem_addr}, {18'd0, addr[ADDR_W+1:2]});
        check("req_we", {31'd0, mem_we}, {31'd0, wr});
        if (wr) check("req_wdata", mem_wdata, wdata);
        mem_ack   = (reqc == ack_delay);
        mem_rdata = (reqc == ack_delay) ? rdata : $urandom;
        reqc++;
      end else begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      @(negedge clk);
      #1;
    end

    check("stall_cycles", low, exp_low);
    check("req_cycles", reqc, exp_req);
    check("req_low_done", {31'd0, mem_req}, 32'd0);
    check("load_data", data_from_memory_mem, exp_q.pop_front());
    check("mem_err", {31'd0, mem_err}, {31'd0, exp_err});
    @(negedge clk);
  endtask

  // Stimulus
  initial begin
    rstn                  = 1'b0;
    memread_mem           = 1'b0;
    memwrite_mem          = 1'b0;
    alu_result_mem        = 32'd0;
    write_data_memory_mem = 32'd0;
    mem_rdata             = 32'd0;
    mem_ack               = 1'b0;
    model_data            = 32'd0;
    model_err             = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", {31'd0, data_ready_mem}, 32'd1);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_data", data_from_memory_mem, 32'd0);
    check("rst_err", {31'd0, mem_err}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    idle_cycle();

    // Load, ack in the second REQ cycle: three stall cycles then ready.
    do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1);
    check("load_deadbeef_kind", 32'(model_data != 32'd0), 32'd1);
    // Store: data register must not move.
    do_access(1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678, 2);
    // Load with no ack: timeout after TMO request cycles.
    do_access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 99);
    // Out-of-range load.
    do_access(1'b1, 1'b0, 32'h8000_0000, 32'h0, 0);
    // Boundaries: ack on the last allowed cycle, top word, first illegal word,
    // low address bits ignored, read+write treated as store, back-to-back.
    do_access(1'b1, 1'b0, 32'h0000_FFFC, 32'h0, TMO - 1);
    do_access(1'b1, 1'b0, 32'h0000_0013, 32'h0, 0);
    do_access(1'b1, 1'b1, 32'h0000_0104, 32'hCAFE_F00D, 0);
    do_access(1'b0, 1'b1, 32'h0001_0000, 32'h5555_AAAA, 0);
    idle_cycle();

    // Reset in the middle of a store request, then a spurious ack.
    memread_mem           = 1'b0;
    memwrite_mem          = 1'b1;
    alu_result_mem        = 32'h0000_0040;
    write_data_memory_mem = 32'hA5A5_A5A5;
    mem_ack               = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_req", {31'd0, mem_req}, 32'd1);
    rstn = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, data_ready_mem}, 32'd1);
    check("mid_rst_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_we", {31'd0, mem_we}, 32'd0);
    check("mid_rst_addr", {18'd0, mem_addr}, 32'd0);
    check("mid_rst_wdata", mem_wdata, 32'd0);
    check("mid_rst_data", data_from_memory_mem, 32'd0);
    check("mid_rst_err", {31'd0, mem_err}, 32'd0);
    check("mid_rst_state", {30'd0, state_dbg}, 32'd0);
    @(negedge clk);
    rstn         = 1'b1;
    memwrite_mem = 1'b0;
    mem_ack      = 1'b1;
    mem_rdata    = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("late_ack_state", {30'd0, state_dbg}, 32'd0);
    check("late_ack_req", {31'd0, mem_req}, 32'd0);
    check("late_ack_ready", {31'd0, data_ready_mem}, 32'd1);
    check("late_ack_data", data_from_memory_mem, 32'd0);
    model_data = 32'd0;
    model_err  = 1'b0;
    exp_q.delete();
    @(negedge clk);

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      int          kind;
      int          op;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      op   = $urandom_range(0, 2);
      a    = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h0001_0000) : ($urandom & 32'h0000_FFFF);
      if (kind == 0) idle_cycle();
      else do_access(op != 1, op != 0, a, $urandom, $urandom_range(0, TMO + 1));
    end
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
